sl_host_bridge: RTL and testbench
=================================

// Module: sl_host_bridge
// PURPOSE
//  Host-side front end of the same-latency interconnect tree. Converts a core's
//  valid/ready command stream into SL_REQ beats for the tree root, and returns
//  read data to the core through a credit-protected response FIFO. The tree has
//  no backpressure, so all flow control lives here. Expected-response tracking
//  flags protocol errors.
// PARAMETERS
//  ADDR_W     32  address width; must match sl_pkg::SL_ADDR_W
//  DATA_W     32  data width; must match sl_pkg::SL_DATA_W
//  RT_LAT     8   fixed round-trip latency: host_req read beat at T -> host_res at T+RT_LAT
//  FIFO_DEPTH 8   response FIFO entries; power of 2, must be >= 2
// PORTS
//  clk        in   1       clock
//  rst_n      in   1       async active-low reset
//  cmd_valid  in   1       core command valid
//  cmd_ready  out  1       bridge accepts the command this cycle
//  cmd_we     in   1       1 = write, 0 = read
//  cmd_addr   in   ADDR_W  target address; upper bits route through the tree
//  cmd_wdata  in   DATA_W  write data
//  rsp_valid  out  1       read response available
//  rsp_ready  in   1       core consumes the response
//  rsp_rdata  out  DATA_W  read data
//  rsp_err    out  1       response is a synthesized error; a timeout produced it
//  err_unexp  out  1       sticky: host_res.valid arrived with no read expected
//  host_req   out  SL_REQ  request to the tree root
//  host_res   in   SL_RES  response from the tree root
// BEHAVIOUR
//  Reset:
//   - host_req all-zero; cmd_ready=0 during reset, 1 afterwards.
//   - rsp_valid=0, rsp_err=0, err_unexp=0.
//   - FIFO empty; inflight=0; expect shift register cleared.
//  Issue path:
//   - The handshake is cmd_valid&cmd_ready. host_req is registered.
//   - On a handshake at cycle T, host_req.valid=1 at T+1 with {wen,addr,wdata}. Otherwise host_req.valid=0.
//  Credits:
//   - credits = FIFO_DEPTH - fifo_count - inflight_reads.
//   - Reads require credits>0. Writes need no credit and return no response.
//   - cmd_ready = !(cmd_valid & !cmd_we & credits==0).
//   - The credit computation uses registered counts only; there is no combinational path from rsp_ready.
//  Expect tracking:
//   - RT_LAT-bit shift register. A 1 enters when a read beat leaves on host_req.
//   - Bit RT_LAT-1 marks the cycle a response is due. inflight_reads = popcount.
//  Response capture:
//   - Due and host_res.valid: push {rdata, err=0}.
//   - Due and !host_res.valid: push {rdata=0, err=1} (timeout).
//   - Not due and host_res.valid: set err_unexp; data is dropped.
//   - Credits guarantee the FIFO is never full on a push. Overflow is an assertion failure.
//  FIFO:
//   - First-word fall-through. rsp_valid = !empty. Pop on rsp_valid&rsp_ready.
//   - Push and pop in the same cycle: count unchanged.
//   - Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Full and empty are derived from a count register that is log2(FIFO_DEPTH)+1 bits wide.
//  Ordering: responses are returned in issue order; the same-latency tree guarantees it.
//  Reset mid-operation: everything in flight is discarded. Late host_res beats after reset are not expected and set err_unexp.
// STRUCTURE
//  sl_pkg:
//   - SL_REQ {valid, wen, addr[SL_ADDR_W], wdata[SL_DATA_W]}
//   - SL_RES {valid, rdata[SL_DATA_W]}
//   - SL_ADDR_W, SL_DATA_W constants
//  sl_pkg is shared with sl21_cell and the tree wrappers.
//  Sub-module: sl_rsp_fifo (FWFT, parameterised WIDTH/DEPTH). Credit and expect logic stay in this module.
// TESTING
//  - Reset release: after rst_n goes 1, cmd_ready=1, host_req.valid=0, rsp_valid=0.
//  - Single read addr=0x40, slave model returns 0xDEAD at +RT_LAT -> rsp_rdata=0xDEAD, rsp_err=0.
//  - 10 back-to-back reads with rsp_ready=0, FIFO_DEPTH=8 -> exactly 8 accepted, cmd_ready=0 on the 9th.
//    Pop one -> the 9th is accepted next cycle.
//  - Back-to-back writes interleaved with reads -> writes are never stalled by zero credits, and no write response is pushed.
//  - Slave model drops one response -> an entry with rsp_err=1, rsp_rdata=0 appears, in order.
//    An injected stray host_res.valid -> err_unexp=1 and stays set until reset.
//  - Assert rst_n=0 with 3 reads in flight, then release -> FIFO empty, credits=FIFO_DEPTH.
//    The late responses set err_unexp.

Source files
------------

// File: rtl/sl_pkg.sv
// Shared types and widths for the same-latency interconnect tree.
// Used by the host bridge, sl21_cell and the tree wrappers.
package sl_pkg;

    localparam int unsigned SL_ADDR_W = 32;
    localparam int unsigned SL_DATA_W = 32;

    typedef struct packed {
        logic                 valid;
        logic                 wen;
        logic [SL_ADDR_W-1:0] addr;
        logic [SL_DATA_W-1:0] wdata;
    } sl_req_t;

    typedef struct packed {
        logic                 valid;
        logic [SL_DATA_W-1:0] rdata;
    } sl_res_t;

endpackage

// File: rtl/sl_rsp_fifo.sv
// First-word fall-through response FIFO for the host bridge.
// Full and empty come from a count register one bit wider than the pointers.
module sl_rsp_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             full;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full    = (count_q == (PW + 1)'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push_i & ~full;
        do_pop   = pop_i & ~empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (PW + 1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (PW + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // The owner's credit scheme must never push into a full FIFO.
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full));

endmodule

// File: rtl/sl_host_bridge.sv
// Host-side front end of the same-latency tree: issues SL_REQ beats, tracks the
// expected read returns and hands read data back through a credit-protected FIFO.
module sl_host_bridge
    import sl_pkg::*;
#(
    parameter int unsigned ADDR_W     = SL_ADDR_W,
    parameter int unsigned DATA_W     = SL_DATA_W,
    parameter int unsigned RT_LAT     = 8,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              err_unexp,
    output sl_req_t           host_req,
    input  sl_res_t           host_res
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + RT_LAT + 2) + 1;
    localparam int unsigned EW = DATA_W + 1;

    sl_req_t           req_q, req_d;
    logic [RT_LAT-1:0] expect_q, expect_d;
    logic              err_unexp_q, err_unexp_d;

    logic [CW-1:0]     inflight;
    logic [CW-1:0]     used;
    logic              credit_zero;
    logic              cmd_hs;
    logic              due;
    logic              fifo_push, fifo_pop, fifo_empty;
    logic [PW:0]       fifo_count;
    logic [EW-1:0]     fifo_wdata, fifo_rdata;

    // A read sitting in the host_req register has consumed a credit but has not
    // yet entered the expect shift register, so it is counted here as well.
    always_comb begin
        inflight = {{(CW - 1){1'b0}}, req_q.valid & ~req_q.wen};
        for (int unsigned i = 0; i < RT_LAT; i++) begin
            inflight = inflight + {{(CW - 1){1'b0}}, expect_q[i]};
        end
        used        = inflight + {{(CW - PW - 1){1'b0}}, fifo_count};
        credit_zero = (used >= CW'(FIFO_DEPTH));
    end

    assign cmd_ready = rst_n & ~(cmd_valid & ~cmd_we & credit_zero);
    assign cmd_hs    = cmd_valid & cmd_ready;

    always_comb begin
        req_d = '0;
        if (cmd_hs) begin
            req_d.valid = 1'b1;
            req_d.wen   = cmd_we;
            req_d.addr  = cmd_addr;
            req_d.wdata = cmd_wdata;
        end

        expect_d = {expect_q[RT_LAT-2:0], req_q.valid & ~req_q.wen};
        due      = expect_q[RT_LAT-1];

        // A due slot always produces an entry; a missing beat becomes a timeout error.
        fifo_push  = due;
        fifo_wdata = host_res.valid ? {1'b0, host_res.rdata} : {1'b1, {DATA_W{1'b0}}};
        fifo_pop   = ~fifo_empty & rsp_ready;

        err_unexp_d = err_unexp_q | (host_res.valid & ~due);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q       <= '0;
            expect_q    <= '0;
            err_unexp_q <= 1'b0;
        end else begin
            req_q       <= req_d;
            expect_q    <= expect_d;
            err_unexp_q <= err_unexp_d;
        end
    end

    sl_rsp_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign host_req  = req_q;
    assign err_unexp = err_unexp_q;
    assign rsp_valid = ~fifo_empty;
    assign rsp_rdata = fifo_rdata[DATA_W-1:0];
    assign rsp_err   = ~fifo_empty & fifo_rdata[DATA_W];

endmodule

// File: tb/tb_sl_host_bridge.sv
// Randomised bench for sl_host_bridge: a transaction-level model (queues of
// outstanding reads and FIFO contents) is compared against the DUT every cycle.
module tb_sl_host_bridge;
    import sl_pkg::*;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned RT_LAT     = 8;
    localparam int unsigned FIFO_DEPTH = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_we = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              err_unexp;
    sl_req_t           host_req;
    sl_res_t           host_res = '0;

    always #5 clk = ~clk;

    sl_host_bridge #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .RT_LAT     (RT_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .err_unexp (err_unexp),
        .host_req  (host_req),
        .host_res  (host_res)
    );

    int vectors = 0;
    int miscompares = 0;
    int unsigned cyc = 0;

    // Model state: response FIFO contents {err, data} and due cycles of accepted reads.
    logic [DATA_W:0]   fq[$];
    int unsigned       infl[$];
    logic [DATA_W-1:0] sched_d[int unsigned];
    sl_req_t           exp_req = '0;
    logic              exp_unexp = 1'b0;

    // Stimulus controls.
    bit                in_rst = 1'b1;
    logic              v_valid = 1'b0, v_we = 1'b0, v_rready = 1'b0;
    logic [31:0]       v_addr = '0, v_wdata = '0;
    int unsigned       drop_pct = 0, stray_pct = 0;
    bit                use_force = 1'b0, force_drop_next = 1'b0, force_stray = 1'b0;
    logic [31:0]       force_data = '0;

    // Values observed at the last compare point.
    logic              obs_acc, obs_ready, obs_rvalid, obs_rerr, obs_unexp, obs_hreq_v;
    logic [31:0]       obs_rdata;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        int      credits;
        logic    exp_ready, hs, pop, due;
        sl_res_t r;
        @(negedge clk);
        if (in_rst) begin
            fq.delete();
            infl.delete();
            exp_req   = '0;
            exp_unexp = 1'b0;
        end
        rst_n     = ~in_rst;
        cmd_valid = v_valid;
        cmd_we    = v_we;
        cmd_addr  = v_addr;
        cmd_wdata = v_wdata;
        rsp_ready = v_rready;
        due = (infl.size() > 0) && (infl[0] == cyc);
        r = '0;
        if (sched_d.exists(cyc)) begin
            r.valid = 1'b1;
            r.rdata = sched_d[cyc];
            sched_d.delete(cyc);
        end else if (!due && (force_stray || $urandom_range(99) < stray_pct)) begin
            r.valid     = 1'b1;
            r.rdata     = $urandom;
            force_stray = 1'b0;
        end
        host_res = r;
        #1;
        credits   = int'(FIFO_DEPTH) - fq.size() - infl.size();
        exp_ready = in_rst ? 1'b0 : !(v_valid && !v_we && credits == 0);
        chk("cmd_ready", cmd_ready, exp_ready);
        chk("host_req", host_req, exp_req);
        chk("rsp_valid", rsp_valid, fq.size() != 0);
        chk("rsp_err", rsp_err, (fq.size() != 0) ? fq[0][DATA_W] : 1'b0);
        if (fq.size() != 0) chk("rsp_rdata", rsp_rdata, fq[0][DATA_W-1:0]);
        chk("err_unexp", err_unexp, exp_unexp);
        obs_acc    = v_valid & cmd_ready;
        obs_ready  = cmd_ready;
        obs_rvalid = rsp_valid;
        obs_rerr   = rsp_err;
        obs_rdata  = rsp_rdata;
        obs_unexp  = err_unexp;
        obs_hreq_v = host_req.valid;
        if (!in_rst) begin
            hs  = v_valid && exp_ready;
            pop = (fq.size() != 0) && v_rready;
            if (pop) void'(fq.pop_front());
            if (due) begin
                void'(infl.pop_front());
                fq.push_back(r.valid ? {1'b0, r.rdata} : {1'b1, {DATA_W{1'b0}}});
            end else if (r.valid) begin
                exp_unexp = 1'b1;
            end
            exp_req = '0;
            if (hs) begin
                exp_req.valid = 1'b1;
                exp_req.wen   = v_we;
                exp_req.addr  = v_addr;
                exp_req.wdata = v_wdata;
                if (!v_we) begin
                    // Beat goes out next cycle; the tree answers RT_LAT after that.
                    infl.push_back(cyc + 1 + RT_LAT);
                    if (force_drop_next) force_drop_next = 1'b0;
                    else if ($urandom_range(99) >= drop_pct)
                        sched_d[cyc + 1 + RT_LAT] = use_force ? force_data : $urandom;
                end
            end
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic set_cmd(input logic valid, input logic we);
        v_valid = valid;
        v_we    = we;
        v_addr  = $urandom;
        v_wdata = $urandom;
    endtask

    task automatic drain(output int pops);
        pops = 0;
        set_cmd(1'b0, 1'b0);
        v_rready = 1'b1;
        for (int i = 0; i < 100 && (fq.size() != 0 || infl.size() != 0); i++) begin
            step();
            pops += int'(obs_rvalid);
        end
    endtask

    initial begin
        int          acc, acc_w, acc_r, k, pops;
        logic        e1, e2, e3;
        logic [31:0] d2;

        in_rst = 1'b1;
        repeat (3) step();
        in_rst = 1'b0;
        step();
        chk("reset_cmd_ready", obs_ready, 1'b1);
        chk("reset_host_req_valid", obs_hreq_v, 1'b0);
        chk("reset_rsp_valid", obs_rvalid, 1'b0);

        // Single read at 0x40 answered with 0xDEAD.
        use_force  = 1'b1;
        force_data = 32'hDEAD;
        set_cmd(1'b1, 1'b0);
        v_addr = 32'h40;
        step();
        chk("rd40_accept", obs_acc, 1'b1);
        set_cmd(1'b0, 1'b0);
        v_rready = 1'b1;
        k = 0;
        do begin
            step();
            k++;
        end while (!obs_rvalid && k < 30);
        chk("rd40_latency", k, 10);
        chk("rd40_rdata", obs_rdata, 32'hDEAD);
        chk("rd40_err", obs_rerr, 1'b0);
        use_force = 1'b0;
        drain(pops);

        // Ten back-to-back reads with no consumer: only FIFO_DEPTH fit.
        v_rready = 1'b0;
        acc = 0;
        repeat (10) begin
            set_cmd(1'b1, 1'b0);
            step();
            acc += int'(obs_acc);
        end
        chk("credit_fill_accepts", acc, 8);
        chk("credit_ninth_stalled", obs_ready, 1'b0);
        set_cmd(1'b0, 1'b0);
        repeat (12) step();
        set_cmd(1'b1, 1'b0);
        v_rready = 1'b1;
        step();
        chk("pop_cycle_still_stalled", obs_ready, 1'b0);
        chk("pop_cycle_rsp_valid", obs_rvalid, 1'b1);
        v_rready = 1'b0;
        step();
        chk("ninth_accepted_after_pop", obs_acc, 1'b1);
        drain(pops);
        chk("drain_after_credit_test", pops, 8);

        // Writes keep flowing while reads are out of credit.
        v_rready = 1'b0;
        repeat (8) begin
            set_cmd(1'b1, 1'b0);
            step();
        end
        acc_w = 0;
        acc_r = 0;
        for (int i = 0; i < 12; i++) begin
            set_cmd(1'b1, (i % 2) == 0);
            step();
            if (v_we) acc_w += int'(obs_acc);
            else acc_r += int'(obs_acc);
        end
        chk("writes_never_stalled", acc_w, 6);
        chk("reads_stalled_no_credit", acc_r, 0);
        drain(pops);
        chk("no_write_responses", pops, 8);

        // Dropped response turns into an in-order timeout entry.
        v_rready = 1'b0;
        set_cmd(1'b1, 1'b0);
        step();
        set_cmd(1'b1, 1'b0);
        force_drop_next = 1'b1;
        step();
        set_cmd(1'b1, 1'b0);
        step();
        set_cmd(1'b0, 1'b0);
        repeat (12) step();
        v_rready = 1'b1;
        step();
        e1 = obs_rerr;
        step();
        e2 = obs_rerr;
        d2 = obs_rdata;
        step();
        e3 = obs_rerr;
        chk("drop_first_ok", e1, 1'b0);
        chk("drop_second_err", e2, 1'b1);
        chk("drop_second_rdata", d2, 32'h0);
        chk("drop_third_ok", e3, 1'b0);

        // Stray beat with nothing expected.
        v_rready = 1'b0;
        force_stray = 1'b1;
        step();
        step();
        chk("stray_sets_unexp", obs_unexp, 1'b1);
        repeat (5) step();
        chk("unexp_sticky", obs_unexp, 1'b1);

        // Reset with three reads outstanding; their late beats are unexpected.
        repeat (3) begin
            set_cmd(1'b1, 1'b0);
            step();
        end
        set_cmd(1'b0, 1'b0);
        in_rst = 1'b1;
        repeat (2) step();
        in_rst = 1'b0;
        step();
        chk("post_reset_rsp_valid", obs_rvalid, 1'b0);
        chk("post_reset_unexp_clear", obs_unexp, 1'b0);
        acc = 0;
        repeat (8) begin
            set_cmd(1'b1, 1'b0);
            step();
            acc += int'(obs_acc);
        end
        chk("post_reset_full_credits", acc, 8);
        chk("late_beats_set_unexp", obs_unexp, 1'b1);
        drain(pops);

        // Random traffic with occasional drops, strays and resets.
        drop_pct  = 5;
        stray_pct = 2;
        for (int i = 0; i < 3000; i++) begin
            set_cmd($urandom_range(99) < 70, $urandom_range(99) < 40);
            v_rready = $urandom_range(99) < 60;
            in_rst = ($urandom_range(499) == 0);
            step();
            in_rst = 1'b0;
        end
        drop_pct  = 0;
        stray_pct = 0;
        drain(pops);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
